// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin instruction-fetch arbiter sharing one RAM read port
// between CPUS requesters. Data-side traffic (dbusy) holds priority over new
// fetch grants; a fetch already in flight is allowed to finish.
//
// Optional feature: define IARB_LINEBUF_EN to compile in a one-entry
// last-word buffer that answers repeat fetches in IDLE without a RAM access.
// dwrite invalidates that buffer; without the macro dwrite has no effect.
//
// Handshake: a requester raises iREN[i] with iaddr[i] and holds both until the
// single cycle in which iwait[i] is low; in that cycle iload[i] carries the
// word. On the RAM side ramREN/ramaddr are held for the whole fetch and
// ramready marks the one cycle in which ramload is valid. Dropping iREN[i]
// before that cycle abandons the request.
module imem_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0][31:0]         iload,
    input  logic                          dbusy,
    input  logic                          dwrite,
    output logic                          ramREN,
    output logic [ADDR_W-1:0]             ramaddr,
    input  logic [31:0]                   ramload,
    input  logic                          ramready,
    output logic                          dbg_state
);

    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q,   ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [ADDR_W-1:0]     addr_q,  addr_d;

    // Round-robin pick results for plain requests and for buffer hits
    logic                  req_found;
    logic [IDX_W-1:0]      req_idx;
    logic                  hit_found;
    logic [IDX_W-1:0]      hit_idx;
    logic [31:0]           hit_data;
    logic [CPUS-1:0]       hit_req;

    // Successor index, wrapping at CPUS
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        int n;
        n = (int'(idx) + 1) % CPUS;
        return IDX_W'(n);
    endfunction

    // First set bit of req searching upward from ptr; MSB of result is "found"
    function automatic logic [IDX_W:0] rr_pick(input logic [CPUS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cidx;
        int               cand;
        res = '0;
        // Walk from the farthest candidate back so the nearest one wins
        for (int i = CPUS - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % CPUS;
            cidx = IDX_W'(cand);
            if (req[cidx]) begin
                res = {1'b1, cidx};
            end
        end
        return res;
    endfunction

    assign dbg_state = state_q;

`ifdef IARB_LINEBUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
    logic [31:0]       buf_data_q,  buf_data_d;

    // Requesters whose address matches the valid buffered word
    always_comb begin
        hit_req = '0;
        for (int c = 0; c < CPUS; c++) begin
            hit_req[c] = iREN[c] && buf_valid_q && (iaddr[c] == buf_addr_q);
        end
        {hit_found, hit_idx} = rr_pick(hit_req, ptr_q);
        hit_data = buf_data_q;
    end

    // Buffer registers; reset only needs to clear valid but all are cleared
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    logic unused_dwrite;

    // No buffer: never a hit, and stores have nothing to invalidate
    always_comb begin
        hit_req   = '0;
        hit_found = 1'b0;
        hit_idx   = '0;
        hit_data  = '0;
    end

    assign unused_dwrite = dwrite;
`endif

    // Round-robin candidate among all active fetch requests
    always_comb begin
        {req_found, req_idx} = rr_pick(iREN, ptr_q);
    end

    // Next-state and output logic for the IDLE/FETCH controller
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        iwait   = '1;
        iload   = '0;
        ramREN  = 1'b0;
        ramaddr = '0;
`ifdef IARB_LINEBUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (hit_found) begin
                    // Buffer hit is answered this cycle, even under dbusy
                    iwait[hit_idx] = 1'b0;
                    iload[hit_idx] = hit_data;
                    ptr_d          = next_idx(hit_idx);
                end else if (!dbusy && req_found) begin
                    grant_d = req_idx;
                    addr_d  = iaddr[req_idx];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!iREN[grant_q]) begin
                    // Requester gave up: abandon without touching the pointer
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = addr_q;
                    if (ramready) begin
                        iwait[grant_q] = 1'b0;
                        iload[grant_q] = ramload;
                        ptr_d          = next_idx(grant_q);
                        state_d        = IDLE;
`ifdef IARB_LINEBUF_EN
                        buf_valid_d = 1'b1;
                        buf_addr_d  = addr_q;
                        buf_data_d  = ramload;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef IARB_LINEBUF_EN
        // A committed store may alias the buffered word; it wins over a load
        if (dwrite) begin
            buf_valid_d = 1'b0;
        end
`endif
    end

    // Controller state, pointer, grant and latched fetch address
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter (CPUS=2, ADDR_W=32). Inputs change on the
// falling edge and outputs are sampled a little later, well clear of the
// rising edge. Each response the bench expects is queued as {cpu, word} and
// popped when an iwait bit goes low.
module tb_imem_arbiter;

    localparam int SB_W = 33;

    logic              CLK;
    logic              nRST;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        iwait;
    logic [1:0][31:0]  iload;
    logic              dbusy;
    logic              dwrite;
    logic              ramREN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramload;
    logic              ramready;
    logic              dbg_state;

    logic [SB_W-1:0]   exp_q[$];
    int                checks;
    int                errors;

    imem_arbiter #(.CPUS(2), .ADDR_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dbusy    (dbusy),
        .dwrite   (dwrite),
        .ramREN   (ramREN),
        .ramaddr  (ramaddr),
        .ramload  (ramload),
        .ramready (ramready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // RAM contents model
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return a * 32'd3 + 32'h1234_0000;
    endfunction

    assign ramload = mem_word(ramaddr);

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        nRST     = 1'b0;
        iREN     = 2'b00;
        iaddr    = '0;
        dbusy    = 1'b0;
        dwrite   = 1'b1;
        ramready = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic exp_push(input logic cpu, input logic [31:0] data);
        exp_q.push_back({cpu, data});
    endtask

    task automatic settle();
        #2;
    endtask

    // Scoreboard monitor for the current cycle, then move to the next falling edge
    task automatic adv();
        int              lows;
        logic [SB_W-1:0] exp;
        logic            ci;
        lows = 0;
        for (int c = 0; c < 2; c++) begin
            ci = c[0];
            if (iwait[ci] === 1'b0) begin
                lows++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: cpu=%0d got=%h required no response", c, iload[ci]);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ci, iload[ci]} !== exp) begin
                        errors++;
                        $display("FAIL resp_data: got cpu=%0d word=%h required cpu=%0d word=%h",
                                 c, iload[ci], exp[32], exp[31:0]);
                    end
                end
            end else begin
                checks++;
                if (iload[ci] !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_iload: cpu=%0d got=%h required 0", c, iload[ci]);
                end
            end
        end
        checks++;
        if (lows > 1) begin
            errors++;
            $display("FAIL one_served: got %0d served required at most 1", lows);
        end
        @(negedge CLK);
    endtask

    task automatic expect_outs(input string name, input logic [1:0] w, input logic ren,
                               input logic [31:0] ra);
        checks++;
        if (iwait !== w || ramREN !== ren || (ren && ramaddr !== ra)) begin
            errors++;
            $display("FAIL %s: got iwait=%b ramREN=%b ramaddr=%h required iwait=%b ramREN=%b ramaddr=%h",
                     name, iwait, ramREN, ramaddr, w, ren, ra);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nRST = 1'b0; iREN = 2'b11; iaddr = '0; dbusy = 1'b0; dwrite = 1'b1; ramready = 1'b1;
        #2;
        checks++;
        if (iwait !== 2'b11 || iload !== '0 || ramREN !== 1'b0 || ramaddr !== 32'h0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got iwait=%b iload=%h ramREN=%b ramaddr=%h st=%b required 11/0/0/0/0",
                     iwait, iload, ramREN, ramaddr, dbg_state);
        end
        apply_reset();
        settle();
        checks++;
        if (iwait !== 2'b11 || iload !== '0 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_outs: got iwait=%b iload=%h ramREN=%b ramaddr=%h required 11/0/0/0",
                     iwait, iload, ramREN, ramaddr);
        end
        @(negedge CLK);
    endtask

    task automatic test_single();
        iREN = 2'b01; iaddr[0] = 32'h40; ramready = 1'b1;
        exp_push(1'b0, 32'hDEADBEEF);
        settle();
        expect_outs("single_idle", 2'b11, 1'b0, 32'h0);
        adv();
        settle();
        expect_outs("single_fetch", 2'b10, 1'b1, 32'h40);
        checks++;
        if (iload[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_data: got %h required deadbeef", iload[0]);
        end
        adv();
        iREN = 2'b00;
        settle();
        adv();
    endtask

    task automatic test_round_robin();
        apply_reset();
        iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; ramready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_push(1'b0, mem_word(32'h100));
            exp_push(1'b1, mem_word(32'h200));
        end
        for (int k = 0; k < 8; k++) begin
            settle();
            adv();
        end
        iREN = 2'b00;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_count: got %0d responses outstanding required 0", exp_q.size());
        end
        settle();
        adv();
    endtask

    task automatic test_dbusy();
        iREN = 2'b10; iaddr[1] = 32'h300; dbusy = 1'b1; ramready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            expect_outs("dbusy_hold", 2'b11, 1'b0, 32'h0);
            adv();
        end
        dbusy = 1'b0;
        exp_push(1'b1, mem_word(32'h300));
        settle();
        expect_outs("dbusy_release_idle", 2'b11, 1'b0, 32'h0);
        adv();
        dbusy = 1'b1;
        settle();
        expect_outs("dbusy_no_abort", 2'b01, 1'b1, 32'h300);
        adv();
        iREN = 2'b00; dbusy = 1'b0;
        settle();
        adv();
    endtask

    task automatic test_abort();
        iREN = 2'b01; iaddr[0] = 32'h500; ramready = 1'b0;
        settle();
        adv();
        settle();
        expect_outs("abort_fetch_wait", 2'b11, 1'b1, 32'h500);
        adv();
        iREN = 2'b00;
        settle();
        expect_outs("abort_drop", 2'b11, 1'b0, 32'h0);
        adv();
        iREN = 2'b11; iaddr[0] = 32'h600; iaddr[1] = 32'h700; ramready = 1'b1;
        exp_push(1'b0, mem_word(32'h600));
        settle();
        adv();
        settle();
        expect_outs("abort_next_cpu0", 2'b10, 1'b1, 32'h600);
        adv();
        iREN = 2'b10;
        exp_push(1'b1, mem_word(32'h700));
        settle();
        adv();
        settle();
        expect_outs("abort_then_cpu1", 2'b01, 1'b1, 32'h700);
        adv();
        iREN = 2'b00;
        settle();
        adv();
    endtask

    task automatic test_reset_mid_fetch();
        iREN = 2'b01; iaddr[0] = 32'h800; ramready = 1'b0;
        settle();
        adv();
        settle();
        expect_outs("mid_fetch_active", 2'b11, 1'b1, 32'h800);
        #1;
        nRST = 1'b0;
        ramready = 1'b1;
        #1;
        checks++;
        if (iwait !== 2'b11 || ramREN !== 1'b0 || iload !== '0) begin
            errors++;
            $display("FAIL mid_fetch_reset: got iwait=%b ramREN=%b iload=%h required 11/0/0",
                     iwait, ramREN, iload);
        end
        @(negedge CLK);
        nRST = 1'b1;
        exp_push(1'b0, mem_word(32'h800));
        settle();
        expect_outs("post_reset_idle", 2'b11, 1'b0, 32'h0);
        adv();
        settle();
        expect_outs("post_reset_fetch", 2'b10, 1'b1, 32'h800);
        adv();
        iREN = 2'b00;
        settle();
        adv();
    endtask

    task automatic test_addr_change();
        iREN = 2'b10; iaddr[1] = 32'h900; ramready = 1'b0;
        settle();
        adv();
        iaddr[1] = 32'hA00;
        settle();
        expect_outs("addr_change_hold", 2'b11, 1'b1, 32'h900);
        adv();
        ramready = 1'b1;
        exp_push(1'b1, mem_word(32'h900));
        settle();
        expect_outs("addr_change_resp", 2'b01, 1'b1, 32'h900);
        adv();
        iREN = 2'b00;
        settle();
        adv();
    endtask

    task automatic test_linebuf();
        apply_reset();
        dwrite = 1'b0;
        iREN = 2'b01; iaddr[0] = 32'h40; ramready = 1'b1;
        exp_push(1'b0, 32'hDEADBEEF);
        settle();
        adv();
        settle();
        expect_outs("lb_first_fetch", 2'b10, 1'b1, 32'h40);
        adv();
        iREN = 2'b00;
        settle();
        adv();
        iREN = 2'b01;
`ifdef IARB_LINEBUF_EN
        dbusy = 1'b1;
        exp_push(1'b0, 32'hDEADBEEF);
        settle();
        expect_outs("lb_hit", 2'b10, 1'b0, 32'h0);
        adv();
        iREN = 2'b00; dbusy = 1'b0; dwrite = 1'b1;
        settle();
        adv();
        dwrite = 1'b0;
        iREN = 2'b01;
`endif
        exp_push(1'b0, 32'hDEADBEEF);
        settle();
        expect_outs("refetch_idle", 2'b11, 1'b0, 32'h0);
        adv();
        settle();
        expect_outs("refetch_ram", 2'b10, 1'b1, 32'h40);
        adv();
        iREN = 2'b00; dwrite = 1'b1;
        settle();
        adv();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_dbusy();
        test_abort();
        test_reset_mid_fetch();
        test_addr_change();
        test_linebuf();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d responses missing required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
